// File: rtl/mmio_console_tx.sv
// MMIO console sink: buffers PUTC bytes in a FIFO and shifts them out as 8N1 UART on tx.
// Latches the first EXIT code and raises exit_valid once all queued output has left the wire.
module mmio_console_tx #(
  parameter logic [31:0] PUTC_ADDR  = 32'h8000_001c,
  parameter logic [31:0] EXIT_ADDR  = 32'h8000_002c,
  parameter logic [31:0] STAT_ADDR  = 32'h8000_0030,
  parameter int unsigned DIVISOR    = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        wready,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        rready,
  input  logic [31:0] raddr,
  output logic        rresp,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        exit_valid,
  output logic [31:0] exit_code
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;

  logic              exit_pending_q, exit_pending_d;
  logic [31:0]       exit_code_q, exit_code_d;
  logic              exit_valid_q, exit_valid_d;
  logic              rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              empty, full, tx_busy, w_fire, push, pop, bit_end;
  logic              unused_wstrb;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign tx_busy = (state_q != StIdle);
  assign bit_end = (cnt_q == CntW'(DIVISOR - 1));

  // Back-pressure comes only from the registered count, so a same-cycle pop never reopens it.
  assign wvalid = !full;
  assign w_fire = wready && wvalid;
  assign push   = w_fire && (waddr == PUTC_ADDR) && wstrb[0] && !exit_pending_q;

  assign unused_wstrb = ^wstrb[3:1];

  // Serializer: pops on leaving IDLE or at the end of STOP, so queued frames run back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the current state one cycle later.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      StStop:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata[7:0];
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_comb begin
    exit_pending_d = exit_pending_q;
    exit_code_d    = exit_code_q;
    if (w_fire && (waddr == EXIT_ADDR) && !exit_pending_q) begin
      exit_pending_d = 1'b1;
      exit_code_d    = wdata;
    end
    exit_valid_d = exit_valid_q || (exit_pending_q && empty && !tx_busy);
  end

  always_comb begin
    rresp_d = rready && (raddr == STAT_ADDR);
    rdata_d = '0;
    if (rresp_d) begin
      rdata_d = {16'h0, 8'(count_q), 4'h0, exit_pending_q, tx_busy, full, empty};
    end
  end

  // Storage is not reset; flushing the pointers and count empties the FIFO.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      bit_q          <= 3'd0;
      shift_q        <= 8'h00;
      tx_q           <= 1'b1;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      exit_pending_q <= 1'b0;
      exit_code_q    <= 32'h0;
      exit_valid_q   <= 1'b0;
      rresp_q        <= 1'b0;
      rdata_q        <= 32'h0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      tx_q           <= tx_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      exit_pending_q <= exit_pending_d;
      exit_code_q    <= exit_code_d;
      exit_valid_q   <= exit_valid_d;
      rresp_q        <= rresp_d;
      rdata_q        <= rdata_d;
    end
  end

  assign tx         = tx_q;
  assign rresp      = rresp_q;
  assign rdata      = rdata_q;
  assign exit_valid = exit_valid_q;
  assign exit_code  = exit_code_q;

endmodule

// File: tb/tb_mmio_console_tx.sv
// Bench for mmio_console_tx: a reference model queues expected bytes and status words;
// a negedge monitor decodes UART frames and read responses and checks them against the queues.
module tb_mmio_console_tx;

  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] PUTC  = 32'h8000_001c;
  localparam logic [31:0] EXIT  = 32'h8000_002c;
  localparam logic [31:0] STAT  = 32'h8000_0030;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        wready = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        rready = 1'b0;
  logic [31:0] raddr = '0;
  logic        wvalid, rresp, tx, exit_valid;
  logic [31:0] rdata, exit_code;

  mmio_console_tx #(
    .PUTC_ADDR (PUTC),
    .EXIT_ADDR (EXIT),
    .STAT_ADDR (STAT),
    .DIVISOR   (D),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .resetb    (resetb),
    .wready    (wready),
    .waddr     (waddr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .rready    (rready),
    .raddr     (raddr),
    .rresp     (rresp),
    .rdata     (rdata),
    .tx        (tx),
    .exit_valid(exit_valid),
    .exit_code (exit_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q [$];
  logic [31:0] rd_q [$];
  int          start_log [$];
  int          last_stop_cyc = -1;
  int          ev_first = -1;
  int          accept_cyc = 0;
  bit          mon_busy = 1'b0;
  bit          stall_seen = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_code = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame and read-response monitor.
  initial begin : monitor
    int         k;
    int         slot;
    int         pos;
    bit         ok;
    logic [7:0] bits;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rresp === 1'b1) begin
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rresp_unexpected: got rdata %h expected no response", rdata);
        end else begin
          check("stat_read", rdata, rd_q.pop_front());
        end
      end
      if (!resetb) begin
        mon_busy = 1'b0;
        ev_first = -1;
      end else begin
        if (exit_valid === 1'b1 && ev_first < 0) ev_first = cyc;
        if (!mon_busy) begin
          if (tx === 1'b0) begin
            mon_busy = 1'b1;
            k = 1;
            ok = 1'b1;
            bits = 8'h00;
            start_log.push_back(cyc);
          end
        end else begin
          slot = k / D;
          pos  = k % D;
          if (slot == 0) begin
            if (tx !== 1'b0) ok = 1'b0;
          end else if (slot <= 8) begin
            if (pos == 0) bits[slot-1] = tx;
            else if (tx !== bits[slot-1]) ok = 1'b0;
          end else begin
            if (tx !== 1'b1) ok = 1'b0;
          end
          k++;
          if (k == 10 * D) begin
            mon_busy = 1'b0;
            last_stop_cyc = cyc;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL frame_unexpected: got byte %h expected no frame", bits);
            end else begin
              e = exp_q.pop_front();
              total++;
              if (!ok || bits !== e) begin
                bad++;
                $display("FAIL frame: got byte %h shape_ok=%0d expected byte %h", bits, ok, e);
              end
            end
          end
        end
      end
    end
  end

  // All driving tasks start and end just after a falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit fired = 1'b0;
    wready = 1'b1;
    waddr  = a;
    wdata  = d;
    wstrb  = s;
    for (int i = 0; i < 2000 && !fired; i++) begin
      fired = wvalid;
      if (!fired) stall_seen = 1'b1;
      @(negedge clk);
    end
    wready = 1'b0;
    if (!fired) begin
      total++;
      bad++;
      $display("FAIL write_timeout: got no accept expected accept of addr %h", a);
    end else begin
      accept_cyc = cyc;
      if (a == PUTC && s[0] && !m_pend) exp_q.push_back(d[7:0]);
      if (a == EXIT && !m_pend) begin
        m_pend = 1'b1;
        m_code = d;
      end
    end
  endtask

  task automatic read_stat(input logic [31:0] exp);
    rready = 1'b1;
    raddr  = STAT;
    rd_q.push_back(exp);
    @(negedge clk);
    rready = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_other(input logic [31:0] a);
    rready = 1'b1;
    raddr  = a;
    @(negedge clk);
    rready = 1'b0;
    check("nonstat_rresp", {31'h0, rresp}, 32'h0);
    check("nonstat_rdata", rdata, 32'h0);
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 5000 && (exp_q.size() != 0 || mon_busy); i++) @(negedge clk);
    if (exp_q.size() != 0 || mon_busy) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    resetb = 1'b0;
    wready = 1'b0;
    rready = 1'b0;
    repeat (n) @(negedge clk);
    resetb = 1'b1;
    exp_q.delete();
    rd_q.delete();
    m_pend = 1'b0;
    m_code = '0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] other [3];
    int          n;
    int          target;
    other[0] = 32'h8000_0010;
    other[1] = STAT;
    other[2] = 32'h0000_001c;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_wvalid", {31'h0, wvalid}, 32'h1);
    check("reset_exit_valid", {31'h0, exit_valid}, 32'h0);
    check("reset_rresp", {31'h0, rresp}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_exit_code", exit_code, 32'h0);
    resetb = 1'b1;
    read_stat(32'h0000_0001);

    // Single frame and its latency
    start_log.delete();
    wr(PUTC, 32'h0000_0041, 4'hf);
    n = accept_cyc;
    wait_drain();
    check("t2_frame_count", start_log.size(), 1);
    if (start_log.size() > 0) check("t2_start_latency", start_log[0], n + 2);
    check("t2_idle_tx", {31'h0, tx}, 32'h1);

    // Overflowing a small FIFO: stalls and contiguous frames
    start_log.delete();
    stall_seen = 1'b0;
    for (int i = 0; i < 8; i++) wr(PUTC, 32'h30 + i, 4'hf);
    wait_drain();
    check("t3_stall_seen", {31'h0, stall_seen}, 32'h1);
    check("t3_frame_count", start_log.size(), 8);
    for (int i = 1; i < start_log.size(); i++) begin
      check("t3_frame_gap", start_log[i] - start_log[i-1], 10 * D);
    end

    // Strobe filtering, same-cycle push/pop, non-status read
    wr(PUTC, 32'h0000_0077, 4'b0010);
    repeat (3) @(negedge clk);
    read_stat(32'h0000_0001);
    wr(PUTC, 32'h0000_00a5, 4'hf);
    wr(PUTC, 32'h0000_005a, 4'hf);
    read_stat(32'h0000_0104);
    wait_drain();
    read_other(PUTC);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(0, 9);
      if (n <= 6) begin
        wr(PUTC, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf);
      end else if (n == 7) begin
        wr(other[$urandom_range(0, 2)], $urandom, 4'hf);
      end else if (n == 8) begin
        read_other(other[0]);
      end else begin
        repeat ($urandom_range(0, 50)) @(negedge clk);
      end
    end
    wait_drain();
    read_stat(32'h0000_0001);

    // EXIT after queued output
    wr(PUTC, 32'h61, 4'hf);
    wr(PUTC, 32'h62, 4'hf);
    wr(PUTC, 32'h63, 4'hf);
    wr(EXIT, 32'h0, 4'hf);
    wr(EXIT, 32'h5, 4'hf);
    wr(PUTC, 32'h55, 4'hf);
    wait_drain();
    repeat (60) @(negedge clk);
    check("t4_exit_valid_rise", ev_first, last_stop_cyc + 1);
    check("t4_exit_valid_sticky", {31'h0, exit_valid}, 32'h1);
    check("t4_exit_code", exit_code, m_code);
    read_stat(32'h0000_0009);

    // Reset in the middle of data bit 3
    do_reset(2);
    wr(PUTC, 32'h0000_005a, 4'hf);
    target = accept_cyc + 2 + 4 * D + 1;
    for (int i = 0; i < 200 && cyc < target; i++) @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    check("t6_tx_after_reset", {31'h0, tx}, 32'h1);
    @(negedge clk);
    resetb = 1'b1;
    exp_q.delete();
    rd_q.delete();
    m_pend = 1'b0;
    m_code = '0;
    check("t6_exit_valid_cleared", {31'h0, exit_valid}, 32'h0);
    read_stat(32'h0000_0001);
    start_log.delete();
    wr(PUTC, 32'h0000_003c, 4'hf);
    wait_drain();
    check("t6_frame_count", start_log.size(), 1);

    check("reads_outstanding", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
